instr_decode_stage: RTL and testbench



---
 rtl/instr_decode_stage.sv | 118 +++++++++++
 tb/tb_instr_decode_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: holds one fetched instruction, decodes it and issues it
// to the ALU operand selector once no in-flight write blocks its sources.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_valid/in_instr fetch handshake and 32-bit instruction word
//   in_ready          decode register can accept this cycle
//   out_valid         held instruction is issuable (loaded and hazard-free)
//   out_ready         downstream accepts the issue
//   alu_sel           select code for the operand selector
//   rd, rs, rt, imm   decoded register/immediate fields of the held instruction
//   wr_en             held instruction writes rd
//   stall_count       cycles spent in HAZ, saturating (only with STALL_CNT_EN)
// Build option: define STALL_CNT_EN to add the stall_count output.
module instr_decode_stage #(
    parameter int WB_LAT  = 3,
    parameter int RADDR_W = 6
) (
    input  logic               clk,
    input  logic               rst,
`ifdef STALL_CNT_EN
    output logic [15:0]        stall_count,
`endif
    input  logic               in_valid,
    input  logic [31:0]        in_instr,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         alu_sel,
    output logic [RADDR_W-1:0] rd,
    output logic [RADDR_W-1:0] rs,
    output logic [RADDR_W-1:0] rt,
    output logic [9:0]         imm,
    output logic               wr_en
);
    typedef enum logic [1:0] {EMPTY, HAZ, RDY} state_t;

    state_t                          r_state, w_state_nxt;
    logic [31:0]                     r_instr, w_instr_nxt;
    logic [WB_LAT-1:0]               r_sb_v, w_sb_v_nxt;
    logic [WB_LAT-1:0][RADDR_W-1:0]  r_sb_rd, w_sb_rd_nxt;
    logic                            w_accept, w_issue, w_held_nxt;

    function automatic logic f_wr(input logic [31:0] x);
        return (x[31:28] inside {4'h4, 4'h5, 4'h6, 4'h8}) && (x[27:22] != 6'd0);
    endfunction

    // The oldest entry is retiring this cycle, so it is already visible and
    // excluded: a write stalls a reader for WB_LAT-1 cycles after its issue.
    function automatic logic f_haz(input logic [31:0] x, input logic [WB_LAT-1:0] v,
                                   input logic [WB_LAT-1:0][RADDR_W-1:0] r);
        logic               use_rs, use_rt;
        logic [RADDR_W-1:0] s, t;
        use_rs = x[31:28] inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9};
        use_rt = x[31:28] inside {4'h4, 4'h5, 4'h9};
        s = RADDR_W'(x[21:16]);
        t = RADDR_W'(x[15:10]);
        f_haz = 1'b0;
        for (int i = 0; i < WB_LAT - 1; i++)
            if (v[i] && ((use_rs && s != '0 && r[i] == s) || (use_rt && t != '0 && r[i] == t)))
                f_haz = 1'b1;
    endfunction

    assign out_valid = (r_state == RDY);
    assign in_ready  = (r_state == EMPTY) || (out_valid && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_issue   = out_valid && out_ready;

    assign alu_sel = (r_instr[31:28] == 4'h4) ? 4'b0100 :
                     (r_instr[31:28] == 4'h5) ? 4'b0011 :
                     (r_instr[31:28] == 4'h6) ? 4'b0010 : 4'b0000;
    assign rd      = RADDR_W'(r_instr[27:22]);
    assign rs      = RADDR_W'(r_instr[21:16]);
    assign rt      = RADDR_W'(r_instr[15:10]);
    assign imm     = r_instr[9:0];
    assign wr_en   = f_wr(r_instr);

    // Next state is judged against the scoreboard as it will look after this
    // edge, so the registered state always equals the live hazard check.
    always_comb begin
        w_sb_v_nxt     = r_sb_v;
        w_sb_rd_nxt    = r_sb_rd;
        w_sb_v_nxt[0]  = w_issue && wr_en;
        w_sb_rd_nxt[0] = rd;
        for (int i = 1; i < WB_LAT; i++) begin
            w_sb_v_nxt[i]  = r_sb_v[i-1];
            w_sb_rd_nxt[i] = r_sb_rd[i-1];
        end
        w_instr_nxt = w_accept ? in_instr : r_instr;
        w_held_nxt  = w_accept || ((r_state != EMPTY) && !w_issue);
        w_state_nxt = !w_held_nxt ? EMPTY :
                      f_haz(w_instr_nxt, w_sb_v_nxt, w_sb_rd_nxt) ? HAZ : RDY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
            r_instr <= '0;
            r_sb_v  <= '0;
            r_sb_rd <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_instr <= w_instr_nxt;
            r_sb_v  <= w_sb_v_nxt;
            r_sb_rd <= w_sb_rd_nxt;
        end
    end

`ifdef STALL_CNT_EN
    logic [15:0] r_stall_cnt;
    assign stall_count = r_stall_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (r_state == HAZ && r_stall_cnt != 16'hFFFF)
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: randomized and directed checks of instr_decode_stage
// against a cycle-count model of in-flight writes.
module tb_instr_decode_stage;
    localparam int WB_LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, wr_en;
    logic [3:0]  alu_sel;
    logic [5:0]  rd, rs, rt;
    logic [9:0]  imm;
`ifdef STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    instr_decode_stage #(.WB_LAT(WB_LAT), .RADDR_W(6)) dut (
        .clk(clk), .rst(rst),
`ifdef STALL_CNT_EN
        .stall_count(stall_count),
`endif
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .alu_sel(alu_sel),
        .rd(rd), .rs(rs), .rt(rt), .imm(imm), .wr_en(wr_en)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_issue [64];
    logic        m_held = 1'b0;
    logic [31:0] m_instr = '0;
    int          m_stalls = 0;
    logic        g_ov, g_ir;
    logic [3:0]  g_alu;

    function automatic logic [31:0] mk(input int op, input int d, input int s, input int t, input int im);
        logic [31:0] x;
        x = {op[3:0], d[5:0], s[5:0], t[5:0], im[9:0]};
        return x;
    endfunction

    function automatic logic [3:0] e_alu(input logic [31:0] x);
        case (x[31:28])
            4'h4: return 4'b0100;
            4'h5: return 4'b0011;
            4'h6: return 4'b0010;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic e_wr(input logic [31:0] x);
        return (x[31:28] == 4'h4 || x[31:28] == 4'h5 || x[31:28] == 4'h6 || x[31:28] == 4'h8) && x[27:22] != 0;
    endfunction

    // A write issued in cycle c becomes visible in cycle c+WB_LAT.
    function automatic logic busy(input logic [5:0] r);
        return r != 0 && (cyc - last_issue[r]) < WB_LAT;
    endfunction

    function automatic logic m_haz(input logic [31:0] x);
        logic [3:0] op;
        op = x[31:28];
        return ((op == 4 || op == 5 || op == 6 || op == 8 || op == 9) && busy(x[21:16])) ||
               ((op == 4 || op == 5 || op == 9) && busy(x[15:10]));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        foreach (last_issue[i]) last_issue[i] = -1000;
        m_held = 1'b0;
        m_instr = '0;
        m_stalls = 0;
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic ordy);
        logic eov, eir;
        @(negedge clk);
        in_valid = v;
        in_instr = ins;
        out_ready = ordy;
        #1;
        g_ov = out_valid;
        g_ir = in_ready;
        g_alu = alu_sel;
        eov = m_held && !m_haz(m_instr);
        eir = !m_held || (eov && ordy);
        chk("out_valid", out_valid, eov);
        chk("in_ready", in_ready, eir);
`ifdef STALL_CNT_EN
        chk("stall_count", stall_count, m_stalls);
`endif
        if (m_held) begin
            chk("alu_sel", alu_sel, e_alu(m_instr));
            chk("rd", rd, m_instr[27:22]);
            chk("rs", rs, m_instr[21:16]);
            chk("rt", rt, m_instr[15:10]);
            chk("imm", imm, m_instr[9:0]);
            chk("wr_en", wr_en, e_wr(m_instr));
            if (!eov) m_stalls++;
        end
        if (eov && ordy && e_wr(m_instr)) last_issue[m_instr[27:22]] = cyc;
        m_held = (v && eir) || (m_held && !(eov && ordy));
        if (v && eir) m_instr = ins;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_fields", {alu_sel, rd, rs, rt, imm, wr_en}, 0);
`ifdef STALL_CNT_EN
        chk("rst_stall_count", stall_count, 0);
`endif
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        model_reset();
        do_reset();
        // dependent ADD -> SUB: two hazard cycles
        step(1, mk(4, 1, 2, 3, 0), 1);
        step(1, mk(5, 4, 1, 5, 0), 1);
        chk("add_valid", g_ov, 1);
        chk("add_alu", g_alu, 4'b0100);
        chk("add_wr_en", wr_en, 1);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 1);
            if (g_ov) break;
            n++;
        end
        chk("haz_cycles", n, 2);
        chk("sub_alu", g_alu, 4'b0011);
`ifdef STALL_CNT_EN
        chk("stall_count_haz", stall_count, 2);
`endif
        repeat (4) step(0, 0, 1);
        // independent stream: one per cycle
        step(1, mk(4, 1, 2, 3, 5), 1);
        chk("stream_ir0", g_ir, 1);
        step(1, mk(6, 2, 3, 0, 6), 1);
        chk("stream_ir1", g_ir, 1);
        step(1, mk(5, 4, 6, 7, 7), 1);
        chk("stream_ir2", g_ir, 1);
        chk("stream_ov2", g_ov, 1);
        step(0, 0, 1);
        chk("stream_ov3", g_ov, 1);
        repeat (4) step(0, 0, 1);
        // held NEG under backpressure, then issue + accept on one edge
        step(1, mk(6, 10, 11, 0, 9), 0);
        for (int k = 0; k < 4; k++) begin
            step(1, mk(4, 12, 13, 14, 1), 0);
            chk("bp_in_ready", g_ir, 0);
            chk("bp_alu", g_alu, 4'b0010);
        end
        step(1, mk(4, 12, 13, 14, 1), 1);
        chk("bp_release_ir", g_ir, 1);
        step(0, 0, 1);
        chk("bp_next_alu", g_alu, 4'b0100);
        repeat (4) step(0, 0, 1);
        // r0 destination never stalls a reader
        step(1, mk(4, 0, 2, 3, 0), 1);
        step(1, mk(5, 5, 0, 1, 0), 1);
        step(0, 0, 1);
        chk("r0_no_stall", g_ov, 1);
        repeat (4) step(0, 0, 1);
        // LOAD r9 then STORE rs=9 stalls; reset in the middle of the stall
        step(1, mk(8, 9, 1, 0, 0), 1);
        step(1, mk(9, 0, 9, 2, 0), 1);
        step(0, 0, 0);
        chk("store_stall", g_ov, 0);
        do_reset();
        step(1, mk(4, 1, 9, 9, 0), 1);
        step(0, 0, 1);
        chk("post_rst_no_stall", g_ov, 1);
        // random traffic with frequent register reuse
        for (int k = 0; k < 3000; k++) begin
            int ops [9] = '{0, 4, 5, 6, 8, 9, 2, 15, 4};
            step($urandom_range(0, 3) != 0,
                 mk(ops[$urandom_range(0, 8)], $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 1023)),
                 $urandom_range(0, 9) < 7);
            if (k == 1500) do_reset();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
